// File: rtl/uart_tx_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_cfg                                                              |
// | UART transmitter: 5..9 data bits, optional parity, 1/2 stop bits,        |
// | run-time baud divisor, valid/ready input handshake.                      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_tx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                 clk_50,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 tx_vld,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_rdy,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int IDX_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DIV_W-1:0]     div_q, div_n;
    logic [DIV_W-1:0]     div_cnt, div_cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic                 stop_idx, stop_idx_n;
    logic                 par, par_n;
    logic                 tx_n;
    logic                 bit_end;

    assign tx_rdy  = (state == IDLE);
    assign busy    = ~tx_rdy;
    assign bit_end = (div_cnt == div_q - DIV_W'(1));

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            div_q    <= '0;
            div_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par      <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            div_q    <= div_n;
            div_cnt  <= div_cnt_n;
            bit_idx  <= bit_idx_n;
            stop_idx <= stop_idx_n;
            par      <= par_n;
            tx       <= tx_n;
        end
    end

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        div_n      = div_q;
        div_cnt_n  = div_cnt;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        par_n      = par;
        tx_done    = 1'b0;

        if (state != IDLE) begin
            div_cnt_n = bit_end ? '0 : div_cnt + DIV_W'(1);
        end

        case (state)
            IDLE: begin
                if (tx_vld) begin
                    state_n   = START;
                    shift_n   = tx_data;
                    // Divisors below 2 would make a bit shorter than the counter can time.
                    div_n     = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
                    par_n     = (PARITY == 1) ? ~^tx_data : ^tx_data;
                    div_cnt_n = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n   = shift >> 1;
                    bit_idx_n = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_n  = '0;
                        stop_idx_n = 1'b0;
                        state_n    = (PARITY != 0) ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_n    = STOP;
                    stop_idx_n = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        tx_done    = 1'b1;
                        stop_idx_n = 1'b0;
                        state_n    = IDLE;
                    end else begin
                        stop_idx_n = stop_idx + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level follows the next state so tx changes on the same edge as the state.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PAR:     tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_cfg                                                           |
// | Scoreboard bench: four transmitter configurations, line-level decoding.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_tx_cfg;

    logic clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    logic        rst_n = 1'b0;
    logic        vld0 = 1'b0, vld1 = 1'b0, vld2 = 1'b0, vld3 = 1'b0;
    logic [7:0]  d0 = '0, d1 = '0, d2 = '0;
    logic [4:0]  d3 = '0;
    logic [15:0] b0 = 16'd4, b1 = 16'd4, b2 = 16'd4, b3 = 16'd4;
    logic        rdy0, rdy1, rdy2, rdy3;
    logic        tx0, tx1, tx2, tx3;
    logic        busy0, busy1, busy2, busy3;
    logic        done0, done1, done2, done3;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pushed[4] = '{0, 0, 0, 0};
    int fdone[4]  = '{0, 0, 0, 0};

    always @(posedge clk_50) cyc <= cyc + 1;

    uart_tx_cfg u0 (
        .clk_50(clk_50), .rst_n(rst_n), .baud_div(b0), .tx_vld(vld0), .tx_data(d0),
        .tx_rdy(rdy0), .tx(tx0), .busy(busy0), .tx_done(done0));
    uart_tx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DIV_W(16)) u1 (
        .clk_50(clk_50), .rst_n(rst_n), .baud_div(b1), .tx_vld(vld1), .tx_data(d1),
        .tx_rdy(rdy1), .tx(tx1), .busy(busy1), .tx_done(done1));
    uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .DIV_W(16)) u2 (
        .clk_50(clk_50), .rst_n(rst_n), .baud_div(b2), .tx_vld(vld2), .tx_data(d2),
        .tx_rdy(rdy2), .tx(tx2), .busy(busy2), .tx_done(done2));
    uart_tx_cfg #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) u3 (
        .clk_50(clk_50), .rst_n(rst_n), .baud_div(b3), .tx_vld(vld3), .tx_data(d3),
        .tx_rdy(rdy3), .tx(tx3), .busy(busy3), .tx_done(done3));

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          div;
        int          acc;
        bit          abort;
    } exp_t;

    exp_t q0[$], q1[$], q2[$], q3[$];

    function automatic logic line(input int k);
        case (k) 0: return tx0; 1: return tx1; 2: return tx2; default: return tx3; endcase
    endfunction
    function automatic logic rdy_of(input int k);
        case (k) 0: return rdy0; 1: return rdy1; 2: return rdy2; default: return rdy3; endcase
    endfunction
    function automatic logic busy_of(input int k);
        case (k) 0: return busy0; 1: return busy1; 2: return busy2; default: return busy3; endcase
    endfunction
    function automatic logic done_of(input int k);
        case (k) 0: return done0; 1: return done1; 2: return done2; default: return done3; endcase
    endfunction

    function automatic int nd(input int k); return (k == 3) ? 5 : 8; endfunction
    function automatic bit pe(input int k); return (k == 1 || k == 2); endfunction
    function automatic int ns(input int k); return (k == 1 || k == 2) ? 2 : 1; endfunction

    function automatic int qsize(input int k);
        case (k) 0: return q0.size(); 1: return q1.size(); 2: return q2.size(); default: return q3.size(); endcase
    endfunction

    task automatic push_exp(input int k, input exp_t e);
        case (k) 0: q0.push_back(e); 1: q1.push_back(e); 2: q2.push_back(e); default: q3.push_back(e); endcase
        pushed[k]++;
    endtask

    task automatic pop_exp(input int k, output exp_t e);
        case (k) 0: e = q0.pop_front(); 1: e = q1.pop_front(); 2: e = q2.pop_front(); default: e = q3.pop_front(); endcase
    endtask

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s u%0d actual=%0d required=%0d", name, k, act, req);
        end
    endtask

    // Line image of a frame: start, data LSB first, hand-computed parity, stop bits.
    function automatic exp_t make_exp(input int k, input logic [7:0] data, input logic parb,
                                      input int div, input int acc, input bit abort);
        exp_t e;
        int   n;
        e.bits = '0;
        n = 1;
        for (int i = 0; i < nd(k); i++) begin e.bits[n] = data[i]; n++; end
        if (pe(k)) begin e.bits[n] = parb; n++; end
        for (int i = 0; i < ns(k); i++) begin e.bits[n] = 1'b1; n++; end
        e.nbits = n;
        e.div   = div;
        e.acc   = acc;
        e.abort = abort;
        return e;
    endfunction

    task automatic drive(input int k, input logic v, input logic [7:0] d, input logic [15:0] b);
        case (k)
            0: begin vld0 = v; d0 = d; b0 = b; end
            1: begin vld1 = v; d1 = d; b1 = b; end
            2: begin vld2 = v; d2 = d; b2 = b; end
            default: begin vld3 = v; d3 = d[4:0]; b3 = b; end
        endcase
    endtask

    task automatic wait_rdy(input int k);
        int n = 0;
        @(negedge clk_50);
        while (rdy_of(k) !== 1'b1 && n < 2000) begin @(negedge clk_50); n++; end
        if (n >= 2000) check("rdy_timeout", k, 0, 1);
    endtask

    task automatic send(input int k, input logic [7:0] data, input logic [15:0] baud, input int div,
                        input logic parb, input bit abort, output int acc);
        wait_rdy(k);
        drive(k, 1'b1, data, baud);
        acc = cyc;
        push_exp(k, make_exp(k, data, parb, div, acc, abort));
        @(negedge clk_50);
        drive(k, 1'b0, data, baud);
    endtask

    task automatic wait_frames(input int k);
        int n = 0;
        while (fdone[k] < pushed[k] && n < 5000) begin @(negedge clk_50); n++; end
        if (n >= 5000) check("frame_timeout", k, fdone[k], pushed[k]);
    endtask

    task automatic monitor(input int k);
        exp_t        e;
        logic [15:0] obs;
        int          hold_bad, done_at, ndone, rdy_bad, n;
        bit          aborted;
        forever begin
            @(negedge clk_50);
            if (rst_n !== 1'b1 || line(k) !== 1'b0) continue;
            if (qsize(k) == 0) begin
                check("spurious_frame", k, 1, 0);
                n = 0;
                while (line(k) !== 1'b1 && n < 5000) begin @(negedge clk_50); n++; end
                continue;
            end
            pop_exp(k, e);
            check("start_latency", k, cyc - e.acc, 1);
            obs = '0; hold_bad = 0; done_at = -1; ndone = 0; rdy_bad = 0; aborted = 0;
            for (int j = 0; j < e.nbits * e.div; j++) begin
                if (j > 0) @(negedge clk_50);
                if (rst_n !== 1'b1) begin aborted = 1; break; end
                if (j % e.div == 0) obs[j / e.div] = line(k);
                else if (line(k) !== obs[j / e.div]) hold_bad++;
                if (done_of(k) === 1'b1) begin ndone++; done_at = j; end
                if (rdy_of(k) !== 1'b0 || busy_of(k) !== 1'b1) rdy_bad++;
            end
            check("abort_expected", k, aborted, e.abort);
            if (aborted) begin
                check("rst_tx_high", k, line(k), 1);
                check("rst_rdy_high", k, rdy_of(k), 1);
                check("rst_busy_low", k, busy_of(k), 0);
                check("rst_no_done", k, ndone, 0);
                n = 0;
                while (rst_n !== 1'b1 && n < 1000) begin @(negedge clk_50); n++; end
            end else begin
                check("frame_bits", k, obs, e.bits);
                check("bit_hold", k, hold_bad, 0);
                check("done_count", k, ndone, 1);
                check("done_cycle", k, done_at, e.nbits * e.div - 1);
                check("rdy_low_in_frame", k, rdy_bad, 0);
                @(negedge clk_50);
                check("rdy_after_done", k, rdy_of(k), 1);
                check("done_after_frame", k, done_of(k), 0);
            end
            fdone[k]++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none

        repeat (3) @(negedge clk_50);
        for (int k = 0; k < 4; k++) begin
            check("reset_tx", k, line(k), 1);
            check("reset_rdy", k, rdy_of(k), 1);
            check("reset_busy", k, busy_of(k), 0);
            check("reset_done", k, done_of(k), 0);
        end
        @(posedge clk_50);
        #1 rst_n = 1'b1;

        // 8N1 basic frames
        send(0, 8'hA5, 16'd4, 4, 1'b0, 0, a);
        wait_frames(0);
        send(0, 8'h00, 16'd3, 3, 1'b0, 0, a);
        wait_frames(0);

        // Parity: even then odd, two stop bits
        send(1, 8'h07, 16'd3, 3, 1'b1, 0, a);
        send(2, 8'h07, 16'd3, 3, 1'b0, 0, a);
        wait_frames(1);
        wait_frames(2);
        send(1, 8'h03, 16'd3, 3, 1'b0, 0, a);
        send(2, 8'hFE, 16'd3, 3, 1'b0, 0, a);
        wait_frames(1);
        wait_frames(2);
        send(1, 8'hFE, 16'd2, 2, 1'b1, 0, a);
        send(2, 8'h03, 16'd2, 2, 1'b1, 0, a);
        wait_frames(1);
        wait_frames(2);

        // Five data bits: upper bits of the word never reach the line
        send(3, 8'h3F, 16'd5, 5, 1'b0, 0, a);
        wait_frames(3);
        send(3, 8'hEA, 16'd5, 5, 1'b0, 0, a);
        wait_frames(3);

        // tx_vld held high across two frames; data changes during frame one; stray pulse in frame two
        wait_rdy(0);
        drive(0, 1'b1, 8'h11, 16'd4);
        a = cyc;
        push_exp(0, make_exp(0, 8'h11, 1'b0, 4, a, 0));
        @(negedge clk_50);
        drive(0, 1'b1, 8'h22, 16'd4);
        push_exp(0, make_exp(0, 8'h22, 1'b0, 4, a + 41, 0));
        while (cyc < a + 42) @(negedge clk_50);
        drive(0, 1'b0, 8'h22, 16'd4);
        while (cyc < a + 60) @(negedge clk_50);
        drive(0, 1'b1, 8'h33, 16'd4);
        @(negedge clk_50);
        drive(0, 1'b0, 8'h33, 16'd4);
        wait_frames(0);
        repeat (60) @(negedge clk_50);

        // Divisors 0 and 1 clamp to 2
        send(0, 8'h5A, 16'd0, 2, 1'b0, 0, a);
        wait_frames(0);
        send(0, 8'hC3, 16'd1, 2, 1'b0, 0, a);
        wait_frames(0);

        // Divisor change mid-frame applies only to the next frame
        send(0, 8'h96, 16'd4, 4, 1'b0, 0, a);
        repeat (10) @(negedge clk_50);
        drive(0, 1'b0, 8'h96, 16'd8);
        wait_frames(0);
        send(0, 8'h69, 16'd8, 8, 1'b0, 0, a);
        wait_frames(0);

        // Reset asserted between edges during the data bits
        send(0, 8'h00, 16'd4, 4, 1'b0, 1, a);
        while (cyc < a + 8) @(negedge clk_50);
        @(posedge clk_50);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk_50);
        #2 rst_n = 1'b1;
        wait_frames(0);
        send(0, 8'h3C, 16'd4, 4, 1'b0, 0, a);
        wait_frames(0);

        repeat (50) @(negedge clk_50);
        for (int k = 0; k < 4; k++) check("queue_empty", k, qsize(k), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
